// File: rtl/pc_unit.sv
// pc_unit -- program-counter unit for the fetch stage.
//
// Holds the current fetch address and advances it by INC each cycle, with
// stall, redirect (branch/jump/resume), halt, and an optional circular
// return-address stack (RAS) for call/return prediction.
//
// Build option:
//   PC_RAS_EN  defined   -> RAS of RAS_DEPTH entries is built.
//              undefined -> no RAS; call_i ignored, ret_i acts as a normal
//                           advance, RAS outputs tied to their empty values.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   stall_i         hold the PC this cycle
//   redirect_i      load redirect_pc_i (highest priority, also leaves HALTED)
//   redirect_pc_i   redirect target
//   call_i          with redirect_i: push pc_o+INC as a return address
//   ret_i           jump to RAS top and pop
//   halt_i          enter HALTED, PC holds
//   pc_o            current fetch address (registered)
//   pc_next_o       pc_o + INC (combinational)
//   halted_o        unit is HALTED
//   ras_top_o       RAS top entry, 0 when empty
//   ras_empty_o     RAS holds no entries
//   ras_full_o      RAS holds RAS_DEPTH entries
//   ras_err_o       sticky RAS overflow/underflow flag, cleared by reset only

module pc_unit #(
  parameter int unsigned          WIDTH     = 16,
  parameter logic [WIDTH-1:0]     RESET_PC  = '0,
  parameter int unsigned          INC       = 2,
  parameter int unsigned          RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  input  logic             call_i,
  input  logic             ret_i,
  input  logic             halt_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_next_o,
  output logic             halted_o,
  output logic [WIDTH-1:0] ras_top_o,
  output logic             ras_empty_o,
  output logic             ras_full_o,
  output logic             ras_err_o
);

`ifdef PC_RAS_EN
  localparam bit RasEn = 1'b1;
`else
  localparam bit RasEn = 1'b0;
`endif

  typedef enum logic {RUN, HALTED} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d, pc_inc;
  logic             do_push, do_pop, set_err;
  logic             ras_empty;
  logic [WIDTH-1:0] ras_top;

  assign pc_inc    = pc_q + WIDTH'(INC);
  assign pc_next_o = pc_inc;
  assign pc_o      = pc_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: redirect always resumes; halt only takes effect when running
  // and not stalled, since stall outranks halt.
  always_comb begin
    state_d = state_q;
    if (redirect_i) begin
      state_d = RUN;
    end else if (state_q == RUN && !stall_i && halt_i) begin
      state_d = HALTED;
    end
  end

  // FSM outputs
  always_comb begin
    halted_o = (state_q == HALTED);
  end

  // PC datapath and RAS control, in priority order
  always_comb begin
    pc_d    = pc_q;
    do_push = 1'b0;
    do_pop  = 1'b0;
    set_err = 1'b0;
    if (redirect_i) begin
      pc_d    = redirect_pc_i;
      do_push = RasEn && call_i;
    end else if (state_q == HALTED || stall_i || halt_i) begin
      pc_d = pc_q;
    end else if (RasEn && ret_i && !ras_empty) begin
      pc_d   = ras_top;
      do_pop = 1'b1;
    end else begin
      pc_d    = pc_inc;
      set_err = RasEn && ret_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

`ifdef PC_RAS_EN
  localparam int unsigned     PtrW    = $clog2(RAS_DEPTH);
  localparam int unsigned     CntW    = $clog2(RAS_DEPTH + 1);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(RAS_DEPTH - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem_q [RAS_DEPTH];
  logic [PtrW-1:0]  top_q, top_d, top_inc, top_dec;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             ras_full;

  // top_q indexes the newest entry; the pointer wraps explicitly so any
  // depth works, not just powers of two.
  assign top_inc   = (top_q == LastIdx) ? '0 : top_q + PtrW'(1);
  assign top_dec   = (top_q == '0) ? LastIdx : top_q - PtrW'(1);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == FullCnt);
  assign ras_top   = ras_empty ? '0 : ras_mem_q[top_q];

  // A push when full silently overwrites the oldest slot (the one top_inc
  // lands on), keeps the count saturated and flags the overflow.
  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (do_push) begin
      top_d = top_inc;
      if (ras_full) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (do_pop) begin
      top_d = top_dec;
      cnt_d = cnt_q - CntW'(1);
    end
    if (set_err) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Entry contents need no reset: an empty stack never exposes them.
  always_ff @(posedge clk) begin
    if (do_push) begin
      ras_mem_q[top_inc] <= pc_inc;
    end
  end

  assign ras_top_o   = ras_top;
  assign ras_empty_o = ras_empty;
  assign ras_full_o  = ras_full;
  assign ras_err_o   = err_q;
`else
  logic unused_ras;

  assign ras_empty   = 1'b1;
  assign ras_top     = '0;
  assign ras_top_o   = '0;
  assign ras_empty_o = 1'b1;
  assign ras_full_o  = 1'b0;
  assign ras_err_o   = 1'b0;
  assign unused_ras  = do_push | do_pop | set_err | call_i | (RAS_DEPTH == 0);
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit -- scoreboard bench for pc_unit (WIDTH=16, RESET_PC=0, INC=2,
// RAS_DEPTH=4). Stimulus pushes the hand-computed post-edge response into a
// queue; a monitor pops and compares it just after each rising edge.
// Expectations adapt to whether PC_RAS_EN is defined for the build.

module tb_pc_unit;

`ifdef PC_RAS_EN
  localparam bit RasOn = 1'b1;
`else
  localparam bit RasOn = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [15:0] pc;
    logic [15:0] pcNext;
    logic        halted;
    logic        rasEmpty;
    logic        rasFull;
    logic        rasErr;
    logic [15:0] rasTop;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirectPc = '0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic        halt = 1'b0;
  logic [15:0] pc, pcNext, rasTop;
  logic        halted, rasEmpty, rasFull, rasErr;

  exp_t expQ[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;

  pc_unit #(
    .WIDTH(16), .RESET_PC(16'h0000), .INC(2), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .stall_i(stall), .redirect_i(redirect), .redirect_pc_i(redirectPc),
    .call_i(call), .ret_i(ret), .halt_i(halt),
    .pc_o(pc), .pc_next_o(pcNext), .halted_o(halted),
    .ras_top_o(rasTop), .ras_empty_o(rasEmpty), .ras_full_o(rasFull),
    .ras_err_o(rasErr)
  );

  always #5 clk = ~clk;

  // Hard stop so the run can never hang
  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic compareField(input string label, input string field,
                              input logic [15:0] act, input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s.%s actual=%h required=%h", label, field, act, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    compareField(e.name, "pc", pc, e.pc);
    compareField(e.name, "pc_next", pcNext, e.pcNext);
    compareField(e.name, "halted", {15'd0, halted}, {15'd0, e.halted});
    compareField(e.name, "ras_empty", {15'd0, rasEmpty}, {15'd0, e.rasEmpty});
    compareField(e.name, "ras_full", {15'd0, rasFull}, {15'd0, e.rasFull});
    compareField(e.name, "ras_err", {15'd0, rasErr}, {15'd0, e.rasErr});
    compareField(e.name, "ras_top", rasTop, e.rasTop);
  endtask

  function automatic exp_t makeExp(input string name, input logic [15:0] ePc,
                                   input bit eHalt, input bit eEmpty, input bit eFull,
                                   input bit eErr, input logic [15:0] eTop);
    exp_t e;
    e.name     = name;
    e.pc       = ePc;
    e.pcNext   = ePc + 16'd2;
    e.halted   = eHalt;
    e.rasEmpty = eEmpty;
    e.rasFull  = eFull;
    e.rasErr   = eErr;
    e.rasTop   = eTop;
    return e;
  endfunction

  // Called at a falling edge: drive one cycle of inputs, queue the response
  // expected after the next rising edge, then move to the next falling edge.
  task automatic applyStimulus(input string name,
                               input bit st, input bit rd, input logic [15:0] rpc,
                               input bit ca, input bit re, input bit ha,
                               input logic [15:0] ePc, input bit eHalt,
                               input bit eEmpty, input bit eFull, input bit eErr,
                               input logic [15:0] eTop);
    stall      = st;
    redirect   = rd;
    redirectPc = rpc;
    call       = ca;
    ret        = re;
    halt       = ha;
    expQ.push_back(makeExp(name, ePc, eHalt, eEmpty, eFull, eErr, eTop));
    @(negedge clk);
  endtask

  // Assert reset at a falling edge, check it took effect before the next
  // rising edge, then release it on the following falling edge.
  task automatic pulseReset(input string name);
    rst_n = 1'b0;
    #1;
    checkOutput(makeExp(name, 16'h0000, 0, 1, 0, 0, 16'h0000));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare one queued expectation after each rising edge
  always @(posedge clk) begin
    #1;
    if (expQ.size() != 0) begin
      cur = expQ.pop_front();
      checkOutput(cur);
    end
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    checkOutput(makeExp("reset", 16'h0000, 0, 1, 0, 0, 16'h0000));
    rst_n = 1'b1;

    // Free-running advance
    applyStimulus("run1", 0,0,16'h0, 0,0,0, 16'h0002, 0, 1,0,0, 16'h0);
    applyStimulus("run2", 0,0,16'h0, 0,0,0, 16'h0004, 0, 1,0,0, 16'h0);
    applyStimulus("run3", 0,0,16'h0, 0,0,0, 16'h0006, 0, 1,0,0, 16'h0);
    applyStimulus("run4", 0,0,16'h0, 0,0,0, 16'h0008, 0, 1,0,0, 16'h0);
    pulseReset("midReset");

    // Stall, then redirect beats stall
    applyStimulus("go10",   0,1,16'h0010, 0,0,0, 16'h0010, 0, 1,0,0, 16'h0);
    applyStimulus("stall1", 1,0,16'h0,    0,0,0, 16'h0010, 0, 1,0,0, 16'h0);
    applyStimulus("stall2", 1,0,16'h0,    0,0,0, 16'h0010, 0, 1,0,0, 16'h0);
    applyStimulus("stall3", 1,0,16'h0,    0,0,0, 16'h0010, 0, 1,0,0, 16'h0);
    applyStimulus("stallRd",1,1,16'h0100, 0,0,0, 16'h0100, 0, 1,0,0, 16'h0);

    // Halt holds against stall/ret/halt/lone call; redirect resumes
    applyStimulus("go20",   0,1,16'h0020, 0,0,0, 16'h0020, 0, 1,0,0, 16'h0);
    applyStimulus("halt",   0,0,16'h0,    0,0,1, 16'h0020, 1, 1,0,0, 16'h0);
    applyStimulus("hold1",  1,0,16'h0,    0,0,0, 16'h0020, 1, 1,0,0, 16'h0);
    applyStimulus("hold2",  0,0,16'h0,    0,1,0, 16'h0020, 1, 1,0,0, 16'h0);
    applyStimulus("hold3",  1,0,16'h0,    0,1,0, 16'h0020, 1, 1,0,0, 16'h0);
    applyStimulus("hold4",  0,0,16'h0,    0,0,1, 16'h0020, 1, 1,0,0, 16'h0);
    applyStimulus("hold5",  0,0,16'h0,    1,0,0, 16'h0020, 1, 1,0,0, 16'h0);
    applyStimulus("resume", 0,1,16'h0000, 0,0,0, 16'h0000, 0, 1,0,0, 16'h0);

    if (RasOn) begin
      // Five calls overflow a 4-deep stack; five returns drain it
      applyStimulus("go10b", 0,1,16'h0010, 0,0,0, 16'h0010, 0, 1,0,0, 16'h0000);
      applyStimulus("call1", 0,1,16'h0020, 1,0,0, 16'h0020, 0, 0,0,0, 16'h0012);
      applyStimulus("call2", 0,1,16'h0030, 1,0,0, 16'h0030, 0, 0,0,0, 16'h0022);
      applyStimulus("call3", 0,1,16'h0040, 1,0,0, 16'h0040, 0, 0,0,0, 16'h0032);
      applyStimulus("call4", 0,1,16'h0050, 1,0,0, 16'h0050, 0, 0,1,0, 16'h0042);
      applyStimulus("call5", 0,1,16'h0060, 1,0,0, 16'h0060, 0, 0,1,1, 16'h0052);
      applyStimulus("ret1",  0,0,16'h0,    0,1,0, 16'h0052, 0, 0,0,1, 16'h0042);
      applyStimulus("ret2",  0,0,16'h0,    0,1,0, 16'h0042, 0, 0,0,1, 16'h0032);
      applyStimulus("ret3",  0,0,16'h0,    0,1,0, 16'h0032, 0, 0,0,1, 16'h0022);
      applyStimulus("ret4",  0,0,16'h0,    0,1,0, 16'h0022, 0, 1,0,1, 16'h0000);
      applyStimulus("ret5",  0,0,16'h0,    0,1,0, 16'h0024, 0, 1,0,1, 16'h0000);
      pulseReset("errClear");
    end

    // Return on an empty stack
    applyStimulus("go08",  0,1,16'h0008, 0,0,0, 16'h0008, 0, 1,0,0,     16'h0);
    applyStimulus("retMt", 0,0,16'h0,    0,1,0, 16'h000A, 0, 1,0,RasOn, 16'h0);
    applyStimulus("errHd", 0,0,16'h0,    0,0,0, 16'h000C, 0, 1,0,RasOn, 16'h0);

    // Wrap at the top of the address space
    applyStimulus("goTop", 0,1,16'hFFFE, 0,0,0, 16'hFFFE, 0, 1,0,RasOn, 16'h0);
    applyStimulus("wrap",  0,0,16'h0,    0,0,0, 16'h0000, 0, 1,0,RasOn, 16'h0);

    // Call then return: predicted in a RAS build, plain advance otherwise
    applyStimulus("callR", 0,1,16'h0040, 1,0,0, 16'h0040, 0, !RasOn,0,RasOn,
                  RasOn ? 16'h0002 : 16'h0000);
    applyStimulus("retR",  0,0,16'h0,    0,1,0, RasOn ? 16'h0002 : 16'h0042, 0,
                  1,0,RasOn, 16'h0000);

    @(negedge clk);
    compareField("drain", "queue", 16'(expQ.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the fetch stage: holds the current fetch address, advances it by a fixed increment, and supports stall, redirect (branch/jump), halt and an optional return-address stack (RAS) for call/return prediction. It sits between the fetch address mux and instruction memory. It replaces the fixed 16-bit always-enabled PC register with a width-generic, controllable unit.

## Interface
- WIDTH, 16, PC width in bits
- RESET_PC, 0, PC value loaded on reset
- INC, 2, sequential increment added to the PC each advance
- RAS_DEPTH, 4, RAS entries (≥2); used only with PC_RAS_EN

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall_i  in  1  hold the PC this cycle
- redirect_i  in  1  load redirect_pc_i (branch/jump/resume)
- redirect_pc_i  in  WIDTH  redirect target
- call_i  in  1  qualifies redirect_i as a call: push return address
- ret_i  in  1  return: jump to RAS top and pop
- halt_i  in  1  halt instruction fetched
- pc_o  out  WIDTH  current fetch address
- pc_next_o  out  WIDTH  pc_o + INC (combinational)
- halted_o  out  1  unit is in HALTED
- ras_top_o  out  WIDTH  RAS top entry (0 when empty)
- ras_empty_o  out  1  RAS holds no entries
- ras_full_o  out  1  RAS holds RAS_DEPTH entries
- ras_err_o  out  1  sticky: RAS overflow or underflow occurred

## Operation
- States: RUN, HALTED. Reset → RUN.
- Per rising edge, first matching rule applies:
  1. redirect_i: pc ← redirect_pc_i; state ← RUN (exits HALTED). If call_i, push pc_o+INC. ret_i is ignored.
  2. HALTED: pc holds. All other inputs ignored.
  3. stall_i: pc holds; no push/pop.
  4. halt_i: state ← HALTED; pc holds (not advanced).
  5. ret_i, RAS non-empty: pc ← ras_top_o; pop.
  6. ret_i, RAS empty: pc ← pc_o+INC; ras_err_o ← 1.
  7. Otherwise: pc ← pc_o+INC.
- call_i without redirect_i is ignored.
- Arithmetic is modulo 2^WIDTH: advancing from all-ones−INC+1 wraps to the low addresses with no flag.
- RAS is circular. A push when full overwrites the oldest entry; the count stays RAS_DEPTH; ras_err_o ← 1. A pop decrements the count, and the next-older entry becomes the top.
- ras_err_o clears only on reset.

## Timing
- Reset values (asynchronous, on rst_n low): pc_o=RESET_PC, halted_o=0, RAS empty (ras_empty_o=1, ras_full_o=0, ras_top_o=0), ras_err_o=0.
- rst_n asserted mid-operation clears the state immediately. Release is sampled at the next clock; the first advance happens on the first edge with rst_n high.
- pc_o, halted_o and all ras_* outputs are registered.
- pc_next_o is combinational from pc_o.
- Redirect latency: 1 cycle (target visible on pc_o after the edge).
- Return latency: 1 cycle. ras_top_o reflects the post-pop top on the same edge.
- Push and redirect on the same edge: the new return address is visible on ras_top_o on the following cycle.

## Configuration
- PC_RAS_EN defined: RAS built as described, RAS_DEPTH entries of WIDTH bits.
- PC_RAS_EN undefined: no RAS storage. call_i is ignored. ret_i is treated as rule 7 (sequential advance). Outputs are tied: ras_top_o=0, ras_empty_o=1, ras_full_o=0, ras_err_o=0.

## Test plan
- Reset then 4 free-running cycles (WIDTH=16, RESET_PC=0, INC=2) -> pc_o = 0,2,4,6,8. Assert rst_n low mid-sequence -> pc_o=0 immediately, before the next edge.
- stall_i high 3 cycles at pc 0x0010, then redirect_i with redirect_pc_i=0x0100 while stall_i stays high -> pc holds at 0x0010 for the stalled edges, then becomes 0x0100 (redirect beats stall).
- halt_i at pc 0x0020 -> halted_o=1, pc stays 0x0020 for 5 cycles despite stall_i/ret_i; then redirect to 0x0000 -> halted_o=0, pc=0x0000.
- PC_RAS_EN, RAS_DEPTH=4: calls from 0x10,0x20,0x30,0x40,0x50 -> ras_full_o after the 4th call; the 5th call sets ras_err_o=1. Five rets -> pc returns 0x52,0x42,0x32,0x22, then sequential advance with ras_empty_o=1.
- ret_i on an empty RAS at pc 0x0008 -> pc=0x000A, ras_err_o=1 and stays set until reset.
- pc_o=0xFFFE with INC=2 advance -> pc_o=0x0000, pc_next_o=0x0002. Build without PC_RAS_EN: call+redirect to 0x40 then ret_i -> pc 0x40 then 0x42, ras_empty_o=1.
